// File: rtl/dcache_miss_ctrl_if.sv
// Signal bundle between the dcache miss controller, the CPU LSU,
// the dcache array and the shared nibble memory port.
interface dcache_miss_ctrl_if #(
    parameter int PA = 22,
    parameter int LB = 2
);
    logic          cpu_req;
    logic          cpu_write;
    logic          cpu_fault;
    logic          cpu_ready;
    logic          c_hit;
    logic          c_push;
    logic [PA-LB-1:0] c_tag;
    logic [PA-LB-1:0] c_vtag;
    logic          c_rstrobe;
    logic          c_wstrobe;
    logic [3:0]    c_dwrite;
    logic [3:0]    c_dread;
    logic          mem_req;
    logic          mem_we;
    logic [PA-1:0] mem_addr;
    logic          mem_gnt;
    logic [3:0]    mem_wdata;
    logic [3:0]    mem_rdata;
    logic          mem_rvalid;
    logic          proto_err;

    modport master (
        input  cpu_req, cpu_write, cpu_fault,
        input  c_hit, c_push, c_tag, c_vtag, c_dwrite,
        input  mem_gnt, mem_rdata, mem_rvalid,
        output cpu_ready, c_rstrobe, c_wstrobe, c_dread,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output proto_err
    );

    modport slave (
        output cpu_req, cpu_write, cpu_fault,
        output c_hit, c_push, c_tag, c_vtag, c_dwrite,
        output mem_gnt, mem_rdata, mem_rvalid,
        input  cpu_ready, c_rstrobe, c_wstrobe, c_dread,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  proto_err
    );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// Dcache miss sequencer: victim write-back, line fill over the
// nibble memory bus, and CPU stall until the access hits.
module dcache_miss_ctrl #(
    parameter int LINE_LENGTH = 4,
    parameter int PA          = 22
) (
    input logic             clk,
    input logic             reset,
    dcache_miss_ctrl_if.master bus
);
    localparam int NNIB = 2 * LINE_LENGTH;
    localparam int LB   = $clog2(LINE_LENGTH);
    localparam int CW   = $clog2(NNIB);
    localparam int TW   = PA - LB;

    typedef enum logic [2:0] {
        IDLE,
        WB_CMD,
        WB_DATA,
        FILL_CMD,
        FILL_DATA,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] tag_q, tag_d;
    logic [TW-1:0] vtag_q, vtag_d;
    logic          last;
    logic          unused;

    // Stores and loads miss identically; the write flag is not needed.
    assign unused = bus.cpu_write;

    assign last          = (count_q == CW'(NNIB - 1));
    assign bus.mem_wdata = bus.c_dwrite;
    assign bus.c_dread   = bus.mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            tag_q   <= '0;
            vtag_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tag_q   <= tag_d;
            vtag_q  <= vtag_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        tag_d         = tag_q;
        vtag_d        = vtag_q;
        bus.cpu_ready = 1'b0;
        bus.c_rstrobe = 1'b0;
        bus.c_wstrobe = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.proto_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (!reset && bus.cpu_req) begin
                    if (bus.cpu_fault || bus.c_hit) begin
                        bus.cpu_ready = 1'b1;
                    end else begin
                        tag_d   = bus.c_tag;
                        vtag_d  = bus.c_vtag;
                        state_d = bus.c_push ? WB_CMD : FILL_CMD;
                    end
                end
            end
            WB_CMD: begin
                bus.mem_req  = 1'b1;
                bus.mem_we   = 1'b1;
                bus.mem_addr = {vtag_q, {LB{1'b0}}};
                if (bus.mem_gnt) begin
                    state_d = WB_DATA;
                    count_d = '0;
                end
            end
            WB_DATA: begin
                bus.c_rstrobe = 1'b1;
                if (last) begin
                    state_d = FILL_CMD;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            FILL_CMD: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {tag_q, {LB{1'b0}}};
                if (bus.mem_gnt) begin
                    state_d = FILL_DATA;
                    count_d = '0;
                end
            end
            FILL_DATA: begin
                bus.c_wstrobe = bus.mem_rvalid;
                if (bus.mem_rvalid) begin
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end else if (count_q != '0) begin
                    // Gap mid-line: abandon, the line is never validated.
                    bus.proto_err = 1'b1;
                    state_d       = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Scoreboard bench for dcache_miss_ctrl: directed misses, hits,
// faults, delayed grants, fill gaps and reset mid-burst.
module tb_dcache_miss_ctrl;
    localparam int PA = 22;
    localparam int LB = 2;
    localparam int TW = PA - LB;

    logic clk = 1'b0;
    logic reset;

    dcache_miss_ctrl_if #(.PA(PA), .LB(LB)) bus ();

    dcache_miss_ctrl #(
        .LINE_LENGTH(4),
        .PA(PA)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [PA:0] cmd_q[$];
    logic [3:0]  wb_q[$];
    logic [3:0]  fill_q[$];
    int          exp_ready = 0;
    int          exp_proto = 0;

    function automatic logic [3:0] vnib(int i);
        return 4'((i * 3 + 5) & 15);
    endfunction

    // Cache array model: read offset advances on strobe, resets on a gap.
    int off = 0;
    always @(posedge clk) begin
        off <= bus.c_rstrobe ? (off + 1) % 8 : 0;
    end
    always_comb bus.c_dwrite = vnib(off);

    logic        pend = 1'b0;
    logic [PA:0] pcmd;

    always @(negedge clk) begin
        logic [PA:0] e;
        logic [3:0]  d;
        if (bus.cpu_ready) begin
            checks++;
            if (exp_ready == 0) begin
                errors++;
                $display("FAIL ready: got 1 expected 0");
            end else begin
                exp_ready--;
            end
        end
        if (bus.proto_err) begin
            checks++;
            if (exp_proto == 0) begin
                errors++;
                $display("FAIL proto_err: got 1 expected 0");
            end else begin
                exp_proto--;
            end
        end
        if (pend) begin
            checks++;
            if (!bus.mem_req || {bus.mem_we, bus.mem_addr} !== pcmd) begin
                errors++;
                $display("FAIL cmd_stable: got req=%0b %h expected %h",
                         bus.mem_req, {bus.mem_we, bus.mem_addr}, pcmd);
            end
        end
        if (bus.mem_req) begin
            checks++;
            if (bus.c_rstrobe || bus.c_wstrobe) begin
                errors++;
                $display("FAIL strobe_in_cmd: got r=%0b w=%0b expected 0",
                         bus.c_rstrobe, bus.c_wstrobe);
            end
            if (cmd_q.size() == 0) begin
                errors++;
                $display("FAIL cmd: got req %h expected none",
                         {bus.mem_we, bus.mem_addr});
            end else if (bus.mem_gnt) begin
                checks++;
                e = cmd_q.pop_front();
                if ({bus.mem_we, bus.mem_addr} !== e) begin
                    errors++;
                    $display("FAIL cmd: got %h expected %h",
                             {bus.mem_we, bus.mem_addr}, e);
                end
            end
        end
        pend = bus.mem_req && !bus.mem_gnt;
        pcmd = {bus.mem_we, bus.mem_addr};
        if (bus.c_rstrobe) begin
            checks++;
            if (wb_q.size() == 0) begin
                errors++;
                $display("FAIL wb: got strobe expected none");
            end else begin
                d = wb_q.pop_front();
                if (bus.mem_wdata !== d) begin
                    errors++;
                    $display("FAIL wb: got %h expected %h",
                             bus.mem_wdata, d);
                end
            end
        end
        if (bus.c_wstrobe) begin
            checks++;
            if (fill_q.size() == 0) begin
                errors++;
                $display("FAIL fill: got strobe expected none");
            end else begin
                d = fill_q.pop_front();
                if (bus.c_dread !== d) begin
                    errors++;
                    $display("FAIL fill: got %h expected %h",
                             bus.c_dread, d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(string name);
        logic [5:0] o;
        o = {bus.cpu_ready, bus.c_rstrobe, bus.c_wstrobe,
             bus.mem_req, bus.mem_we, bus.proto_err};
        checks++;
        if (o !== 6'b0) begin
            errors++;
            $display("FAIL %s: got outputs %b expected 000000", name, o);
        end
    endtask

    task automatic serve_cmd(int delay);
        int n;
        n = 0;
        while (!bus.mem_req && n < 30) begin
            tick();
            n++;
        end
        if (!bus.mem_req) begin
            checks++;
            errors++;
            $display("FAIL cmd_timeout: got no mem_req expected one");
        end else begin
            repeat (delay) tick();
            bus.mem_gnt = 1'b1;
            tick();
            bus.mem_gnt = 1'b0;
        end
    endtask

    task automatic fill(int wait_n, int gap_at, int seed);
        bus.mem_rvalid = 1'b0;
        repeat (wait_n) tick();
        for (int i = 0; i < 8; i++) begin
            if (i == gap_at) begin
                bus.mem_rvalid = 1'b0;
                tick();
                return;
            end
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 4'(seed + i);
            tick();
        end
        bus.mem_rvalid = 1'b0;
        bus.c_hit      = 1'b1;
    endtask

    task automatic push_fill(int seed, int n);
        for (int i = 0; i < n; i++) fill_q.push_back(4'(seed + i));
    endtask

    task automatic push_wb(int n);
        for (int i = 0; i < n; i++) wb_q.push_back(vnib(i));
    endtask

    task automatic wait_ready();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = bus.cpu_ready;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got 0 expected 1");
        end
        tick();
        bus.cpu_req = 1'b0;
        bus.c_hit   = 1'b0;
    endtask

    task automatic start_miss(logic [TW-1:0] t, logic [TW-1:0] v,
                              logic push);
        bus.c_tag   = t;
        bus.c_vtag  = v;
        bus.c_push  = push;
        bus.c_hit   = 1'b0;
        bus.cpu_req = 1'b1;
        tick();
    endtask

    initial begin
        reset          = 1'b1;
        bus.cpu_req    = 1'b0;
        bus.cpu_write  = 1'b0;
        bus.cpu_fault  = 1'b0;
        bus.c_hit      = 1'b0;
        bus.c_push     = 1'b0;
        bus.c_tag      = '0;
        bus.c_vtag     = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rdata  = '0;
        bus.mem_rvalid = 1'b0;
        repeat (3) tick();
        check_idle("reset");
        reset = 1'b0;
        tick();

        // Hit: zero-wait ready
        exp_ready++;
        bus.cpu_req = 1'b1;
        bus.c_hit   = 1'b1;
        tick();
        bus.cpu_req = 1'b0;
        bus.c_hit   = 1'b0;
        tick();

        // Fault: ready without memory traffic
        exp_ready++;
        bus.cpu_req   = 1'b1;
        bus.cpu_fault = 1'b1;
        bus.cpu_write = 1'b1;
        tick();
        bus.cpu_req   = 1'b0;
        bus.cpu_fault = 1'b0;
        bus.cpu_write = 1'b0;
        tick();

        // Clean miss
        cmd_q.push_back({1'b0, 22'h048D14});
        push_fill(0, 8);
        exp_ready++;
        start_miss(20'h12345, 20'h0, 1'b0);
        serve_cmd(0);
        fill(0, -1, 0);
        wait_ready();

        // Dirty miss with a late first nibble
        cmd_q.push_back({1'b1, 22'h000004});
        push_wb(8);
        cmd_q.push_back({1'b0, 22'h0AAAA8});
        push_fill(8, 8);
        exp_ready++;
        start_miss(20'h2AAAA, 20'h00001, 1'b1);
        serve_cmd(0);
        serve_cmd(0);
        fill(2, -1, 8);
        wait_ready();

        // Grant held off 5 cycles, top line address
        cmd_q.push_back({1'b0, 22'h3FFFFC});
        push_fill(3, 8);
        exp_ready++;
        start_miss(20'hFFFFF, 20'h0, 1'b0);
        serve_cmd(5);
        fill(0, -1, 3);
        wait_ready();

        // rvalid gap at nibble 3, then retry
        cmd_q.push_back({1'b0, 22'h002AF0});
        push_fill(6, 3);
        exp_proto++;
        cmd_q.push_back({1'b0, 22'h002AF0});
        push_fill(6, 8);
        exp_ready++;
        start_miss(20'h00ABC, 20'h0, 1'b0);
        serve_cmd(0);
        fill(0, 3, 6);
        serve_cmd(0);
        fill(0, -1, 6);
        wait_ready();

        // Reset during write-back data
        cmd_q.push_back({1'b1, 22'h155554});
        push_wb(3);
        start_miss(20'h11111, 20'h55555, 1'b1);
        serve_cmd(0);
        tick();
        tick();
        reset       = 1'b1;
        bus.cpu_req = 1'b0;
        tick();
        check_idle("reset_wb");
        reset = 1'b0;
        repeat (2) tick();

        checks++;
        if (cmd_q.size() + wb_q.size() + fill_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d left expected 0",
                     cmd_q.size() + wb_q.size() + fill_q.size());
        end
        checks++;
        if (exp_ready != 0 || exp_proto != 0) begin
            errors++;
            $display("FAIL events: got ready=%0d proto=%0d expected 0",
                     exp_ready, exp_proto);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
